// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for the lab serial link (transmitter and receiver).
// Frame layout on the wire: START_BIT, DATA_BITS data bits LSB first,
// one even-parity bit, STOP_BIT -- FRAME_BITS bits in total.
// -----------------------------------------------------------------------------
package serial_link_pkg;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Receiver deframer states. BREAK absorbs a line held low after a bad
    // stop bit so that it cannot be mistaken for a new start bit.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// rx_byte_fifo
// First-word-fall-through FIFO. The head entry is always presented on `head`
// (all zeros when empty), and `pop` retires it at the clock edge.
//
// Ports:
//   clk        clock
//   srst       synchronous active-high reset (empties the FIFO)
//   push       write request; accepted when not full, or when full and a pop
//              retires an entry at the same edge
//   push_data  data to write
//   pop        read request; ignored when empty
//   head       current head entry, zero when empty
//   full       DEPTH entries held
//   empty      no entries held
//   count      occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module rx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_pop;
    logic do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop at the same edge frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    // Storage has no reset: stale entries are never visible because the
    // head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is a register-addressed read of register storage; no input
    // reaches it combinationally.
    assign head  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/serial_rx_deframer.sv
// -----------------------------------------------------------------------------
// serial_rx_deframer
// Samples the serial line once per rx_sclk_i edge, extracts 11-bit frames
// (start 0, 8 data bits LSB first, even parity, stop 1) and pushes good bytes
// into a FWFT FIFO drained with a valid/ready handshake.
//
// Ports:
//   rx_sclk_i         clock (serial bit clock)
//   rx_srst_i         synchronous active-high reset
//   rx_sdata_i        serial line, idles high
//   read_ready_i      consumer pop request, effective while valid is high
//   rx_pdata_o        FIFO head byte, 8'h00 when empty
//   rx_pdata_valid_o  FIFO non-empty
//   rx_fifo_count_o   FIFO occupancy
//   rx_busy_o         deframer not in IDLE
//   parity_err_o      one-cycle pulse: frame dropped for bad parity
//   frame_err_o       one-cycle pulse: frame dropped for bad stop bit
//   overflow_o        sticky: a good byte was lost to a full FIFO
// -----------------------------------------------------------------------------
module serial_rx_deframer
    import serial_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          rx_sclk_i,
    input  logic                          rx_srst_i,
    input  logic                          rx_sdata_i,
    input  logic                          read_ready_i,
    output logic [7:0]                    rx_pdata_o,
    output logic                          rx_pdata_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count_o,
    output logic                          rx_busy_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overflow_o
);

    localparam int CNT_W = $clog2(DATA_BITS);

    rx_state_t              state_reg,  state_next;
    logic [CNT_W-1:0]       cnt_reg,    cnt_next;
    logic [DATA_BITS-1:0]   shreg_reg,  shreg_next;
    logic                   par_reg,    par_next;
    logic                   perr_reg,   perr_next;
    logic                   ferr_reg,   ferr_next;
    logic                   ovf_reg,    ovf_next;
    logic                   busy_reg;

    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign pop = read_ready_i && !fifo_empty;

    always_ff @(posedge rx_sclk_i) begin
        if (rx_srst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            shreg_reg <= '0;
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shreg_reg <= shreg_next;
            par_reg   <= par_next;
            perr_reg  <= perr_next;
            ferr_reg  <= ferr_next;
            ovf_reg   <= ovf_next;
            // Registered from the next state so busy carries no input path.
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shreg_next = shreg_reg;
        par_next   = par_reg;
        perr_next  = 1'b0;
        ferr_next  = 1'b0;
        push       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (rx_sdata_i == START_BIT) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                shreg_next[cnt_reg] = rx_sdata_i;
                cnt_next            = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                    state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                par_next   = rx_sdata_i;
                state_next = ST_STOP;
            end
            ST_STOP: begin
                // A bad stop bit masks any parity problem on the same frame.
                if (rx_sdata_i != STOP_BIT) begin
                    ferr_next  = 1'b1;
                    state_next = ST_BREAK;
                end else if (par_reg != (^shreg_reg)) begin
                    perr_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    push       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (rx_sdata_i == STOP_BIT) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Lost byte only when full and no pop frees a slot at the same edge.
    assign ovf_next = ovf_reg || (push && fifo_full && !pop);

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (rx_sclk_i),
        .srst      (rx_srst_i),
        .push      (push),
        .push_data (shreg_reg),
        .pop       (pop),
        .head      (rx_pdata_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_fifo_count_o)
    );

    assign rx_pdata_valid_o = !fifo_empty;
    assign rx_busy_o        = busy_reg;
    assign parity_err_o     = perr_reg;
    assign frame_err_o      = ferr_reg;
    assign overflow_o       = ovf_reg;

endmodule

// File: tb/tb_serial_rx_deframer.sv
module tb_serial_rx_deframer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       srst;
    logic       sdata;
    logic       rdy;
    logic [7:0] pdata;
    logic       pvalid;
    logic [2:0] fcount;
    logic       busy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    serial_rx_deframer #(.FIFO_DEPTH(DEPTH)) dut (
        .rx_sclk_i        (clk),
        .rx_srst_i        (srst),
        .rx_sdata_i       (sdata),
        .read_ready_i     (rdy),
        .rx_pdata_o       (pdata),
        .rx_pdata_valid_o (pvalid),
        .rx_fifo_count_o  (fcount),
        .rx_busy_o        (busy),
        .parity_err_o     (perr),
        .frame_err_o      (ferr),
        .overflow_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table: frame 8'hC5 then one pop ------
    typedef struct {
        logic       sd;
        logic       rd;
        logic [7:0] e_data;
        logic       e_valid;
        logic [2:0] e_cnt;
        logic       e_busy;
    } vec_t;
    vec_t tbl [12];

    // ---------------- stream records for the model-checked sections -------
    // ev: 0 none, 1 good stop (byte b), 2 parity drop, 3 framing drop
    typedef struct {
        logic       sd;
        logic       rd;
        logic       rst;
        int         ev;
        logic [7:0] b;
        logic       busy;
    } stim_t;
    stim_t sq[$];

    logic [7:0] mq[$];    // reference FIFO contents
    logic       m_ovf;
    logic       rnd_rd;
    logic       cur_rd;

    function automatic logic pick_rd(input int sel);
        if (sel == 0) return 1'b0;
        if (sel == 1) return 1'b1;
        if (rnd_rd) return logic'($urandom_range(0, 1));
        return cur_rd;
    endfunction

    task automatic add_rec(input logic sd, input logic bz, input int ev,
                           input logic [7:0] b, input int rdsel, input logic rst);
        stim_t r;
        r.sd = sd; r.busy = bz; r.ev = ev; r.b = b;
        r.rd = pick_rd(rdsel); r.rst = rst;
        sq.push_back(r);
    endtask

    task automatic add_idle(input int n, input int rdsel);
        for (int i = 0; i < n; i++) add_rec(1'b1, 1'b0, 0, 8'h00, rdsel, 1'b0);
    endtask

    // Builds one frame from the wire format; expected busy/event follow
    // directly from the frame layout.
    task automatic add_frame(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input int hold, input int stop_rd);
        logic par;
        par = (^b) ^ bad_par;
        add_rec(1'b0, 1'b1, 0, 8'h00, -1, 1'b0);
        for (int i = 0; i < 8; i++) add_rec(b[i], 1'b1, 0, 8'h00, -1, 1'b0);
        add_rec(par, 1'b1, 0, 8'h00, -1, 1'b0);
        if (bad_stop) begin
            add_rec(1'b0, 1'b1, 3, b, stop_rd, 1'b0);
            for (int i = 0; i < hold; i++) add_rec(1'b0, 1'b1, 0, 8'h00, -1, 1'b0);
            add_rec(1'b1, 1'b0, 0, 8'h00, -1, 1'b0);
        end else begin
            add_rec(1'b1, 1'b0, bad_par ? 2 : 1, b, stop_rd, 1'b0);
        end
    endtask

    task automatic run_stream();
        stim_t r;
        logic  popd;
        logic [7:0] e_head;
        while (sq.size() > 0) begin
            r = sq.pop_front();
            srst  = r.rst;
            sdata = r.sd;
            rdy   = r.rd;
            @(posedge clk);
            #1;
            if (r.rst) begin
                mq.delete();
                m_ovf = 1'b0;
                r.ev  = 0;
                r.busy = 1'b0;
                $display("reset applied");
            end else begin
                popd = r.rd && (mq.size() > 0);
                if (popd) begin
                    $display("pop  0x%02h", mq[0]);
                    void'(mq.pop_front());
                end
                if (r.ev == 1) begin
                    // after any pop, room exists unless full with no pop
                    if (mq.size() < DEPTH) begin
                        mq.push_back(r.b);
                        $display("recv 0x%02h", r.b);
                    end else begin
                        m_ovf = 1'b1;
                        $display("lost 0x%02h (overflow)", r.b);
                    end
                end else if (r.ev == 2) begin
                    $display("parity drop 0x%02h", r.b);
                end else if (r.ev == 3) begin
                    $display("framing drop");
                end
            end
            e_head = (mq.size() > 0) ? mq[0] : 8'h00;
            chk("pdata",  32'(pdata),  32'(e_head));
            chk("valid",  32'(pvalid), 32'(mq.size() > 0));
            chk("count",  32'(fcount), 32'(mq.size()));
            chk("busy",   32'(busy),   32'(r.busy));
            chk("perr",   32'(perr),   32'(r.ev == 2));
            chk("ferr",   32'(ferr),   32'(r.ev == 3));
            chk("ovf",    32'(ovf),    32'(m_ovf));
        end
        srst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // start
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d0
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d1
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d2
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d3
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d4
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d5
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d6
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // d7
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1}; // parity
        tbl[10] = '{1'b1, 1'b0, 8'hC5, 1'b1, 3'd1, 1'b0}; // stop
        tbl[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}; // pop

        m_ovf  = 1'b0;
        rnd_rd = 1'b0;
        cur_rd = 1'b0;
        srst   = 1'b1;
        sdata  = 1'b1;
        rdy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pdata", 32'(pdata),  32'h00);
        chk("rst_valid", 32'(pvalid), 32'd0);
        chk("rst_count", 32'(fcount), 32'd0);
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_perr",  32'(perr),   32'd0);
        chk("rst_ferr",  32'(ferr),   32'd0);
        chk("rst_ovf",   32'(ovf),    32'd0);
        srst = 1'b0;
        add_idle(2, 0);
        run_stream();

        // Table: frame 197 (0xC5) and its pop.
        for (int i = 0; i < 12; i++) begin
            sdata = tbl[i].sd;
            rdy   = tbl[i].rd;
            @(posedge clk);
            #1;
            chk("tbl_pdata", 32'(pdata),  32'(tbl[i].e_data));
            chk("tbl_valid", 32'(pvalid), 32'(tbl[i].e_valid));
            chk("tbl_count", 32'(fcount), 32'(tbl[i].e_cnt));
            chk("tbl_busy",  32'(busy),   32'(tbl[i].e_busy));
            chk("tbl_perr",  32'(perr),   32'd0);
            chk("tbl_ferr",  32'(ferr),   32'd0);
        end
        $display("table frame 0xC5 done");
        rdy = 1'b0;

        // Back-to-back frames, then one pop per cycle.
        add_frame(8'd97,  1'b0, 1'b0, 0, 0);
        add_frame(8'd64,  1'b0, 1'b0, 0, 0);
        add_frame(8'd12,  1'b0, 1'b0, 0, 0);
        add_frame(8'd254, 1'b0, 1'b0, 0, 0);
        add_idle(6, 1);
        // Parity error followed by a good frame.
        add_frame(8'd97, 1'b1, 1'b0, 0, 0);
        add_frame(8'd12, 1'b0, 1'b0, 0, 0);
        add_idle(3, 1);
        // Framing error with the line held low, then a good frame.
        add_frame(8'd33, 1'b0, 1'b1, 5, 0);
        add_frame(8'd64, 1'b0, 1'b0, 0, 0);
        add_idle(3, 1);
        // Five frames without draining: overflow, sticky, first four kept.
        for (int i = 1; i <= 5; i++) add_frame(8'(i * 17), 1'b0, 1'b0, 0, 0);
        add_idle(4, 0);
        add_idle(6, 1);
        // Fresh start, repeat with a pop on the fifth stop edge.
        add_rec(1'b1, 1'b0, 0, 8'h00, 0, 1'b1);
        add_idle(1, 0);
        for (int i = 1; i <= 4; i++) add_frame(8'(i * 3), 1'b0, 1'b0, 0, 0);
        add_frame(8'hA5, 1'b0, 1'b0, 0, 1);
        add_idle(6, 1);
        // Reset during data bit 4 of 197 with a byte already queued.
        add_frame(8'h33, 1'b0, 1'b0, 0, 0);
        add_rec(1'b0, 1'b1, 0, 8'h00, 0, 1'b0);
        for (int i = 0; i < 4; i++) add_rec(logic'((8'd197 >> i) & 8'd1), 1'b1, 0, 8'h00, 0, 1'b0);
        add_rec(1'b0, 1'b0, 0, 8'h00, 0, 1'b1);
        add_idle(2, 0);
        add_frame(8'd12, 1'b0, 1'b0, 0, 0);
        add_idle(3, 1);
        run_stream();

        // Randomized traffic with random consumer readiness.
        rnd_rd = 1'b1;
        for (int f = 0; f < 150; f++) begin
            add_frame(8'($urandom_range(0, 255)),
                      logic'($urandom_range(0, 7) == 0),
                      logic'($urandom_range(0, 9) == 0),
                      int'($urandom_range(0, 3)), -1);
            add_idle(int'($urandom_range(0, 2)), -1);
        end
        add_idle(8, 1);
        run_stream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_rx_deframer.md
# serial_rx_deframer

Receive-side deframer for the lab serial link. It samples the serial line once per `rx_sclk_i` edge and extracts 11-bit frames: start 0, 8 data bits LSB first, even parity, stop 1. Each good byte is pushed into a small first-word-fall-through FIFO, which the parallel consumer drains through a valid/ready handshake. Parity, framing and overflow errors are reported on status outputs.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `rx_sclk_i` in 1: serial-domain clock; the only clock in the block.
- `rx_srst_i` in 1: synchronous, active-high reset.
- `rx_sdata_i` in 1: serial line; idles high; one bit per `rx_sclk_i` cycle.
- `read_ready_i` in 1: consumer pop request; takes effect at an edge where `rx_pdata_valid_o` is high.
- `rx_pdata_o` out 8: FIFO head byte; 8'h00 when empty.
- `rx_pdata_valid_o` out 1: FIFO non-empty.
- `rx_fifo_count_o` out $clog2(FIFO_DEPTH)+1: occupancy, 0..FIFO_DEPTH.
- `rx_busy_o` out 1: high in every state except IDLE.
- `parity_err_o` out 1: one-cycle pulse when a frame is dropped for bad parity.
- `frame_err_o` out 1: one-cycle pulse when a frame is dropped for a bad stop bit.
- `overflow_o` out 1: sticky; a good byte arrived while the FIFO was full. Cleared only by reset.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: `rx_sdata_i`=0 sampled → DATA, with bit counter = 0. Otherwise stay.
- DATA: shift the sampled bit into `shreg[cnt]` (LSB first) and increment `cnt`. After bit 7 → PARITY.
- PARITY: latch the parity bit → STOP. Parity is even: the required bit is the XOR of the 8 data bits.
- STOP, by priority:
  - `rx_sdata_i`=0: pulse `frame_err_o`, drop the byte, → BREAK.
  - Stop bit good but parity mismatch: pulse `parity_err_o`, drop the byte, → IDLE.
  - Otherwise push the byte, → IDLE.
- BREAK: wait for `rx_sdata_i`=1, then → IDLE. A held-low line never produces a spurious start.
- Parity error and framing error on the same frame: only `frame_err_o` pulses.
- FIFO push on a good stop:
  - FIFO not full: byte accepted.
  - FIFO full with no pop that edge: byte dropped, `overflow_o` set.
  - FIFO full with a pop that same edge: push accepted, count stays FIFO_DEPTH, no overflow.
- Pop: `read_ready_i` && `rx_pdata_valid_o` → head advances at that edge. Pop when empty is ignored.
- Simultaneous push and pop (not full): count unchanged, ordering preserved.
- Pointers wrap modulo FIFO_DEPTH. Count saturates by construction; it never exceeds FIFO_DEPTH and never underflows.
- Reset, including mid-frame: state IDLE, counter 0, FIFO emptied, in-flight byte discarded, all flags cleared.

## Timing
- Reset values: `rx_pdata_o`=8'h00, `rx_pdata_valid_o`=0, `rx_fifo_count_o`=0, `rx_busy_o`=0, `parity_err_o`=0, `frame_err_o`=0, `overflow_o`=0.
- Start bit sampled at edge t:
  - data bits sampled at t+1..t+8, parity at t+9, stop at t+10;
  - byte visible on `rx_pdata_o` with valid high after edge t+10.
  - Error pulses are high for exactly the cycle after edge t+10.
- Back-to-back frames: the next start bit may be sampled at t+11 with no idle gap. Sustained rate is 1 byte per 11 cycles.
- Pop latency: after the popping edge, the next byte (or 8'h00/valid low) appears the following cycle. There is no bubble when FIFO occupancy is ≥2.
- All outputs are registered or driven directly from registers; there is no combinational path from any input to any output.

## Structure
- Package `serial_link_pkg`:
  - frame constants `FRAME_BITS`=11, `DATA_BITS`=8, `START_BIT`=1'b0, `STOP_BIT`=1'b1;
  - FSM state enum `rx_state_t`;
  - shared with the transmitter.
- Sub-module `rx_byte_fifo`: parameterized FWFT FIFO with push/pop/full/empty/count; the deframer instantiates one.
- The deframer holds the FSM, bit counter, shift register, parity XOR and error flags.

## Test plan
- Reset, then frame 8'd197 (parity 0, stop 1) → after 11 cycles `rx_pdata_o`=8'hC5, valid=1, count=1, no error pulses.
- Back-to-back 97, 64, 12, 254 (parities 1,1,0,1), then pop one per cycle → reads 8'h61, 8'h40, 8'h0C, 8'hFE in order, then valid=0 and `rx_pdata_o`=8'h00.
- 8'd97 sent with parity bit 0 → `parity_err_o` pulses one cycle, count unchanged. The following good frame 8'd12 is received normally.
- Frame with stop bit 0, line held low 5 more cycles, then high → one `frame_err_o` pulse, no extra frames decoded, a later 8'd64 is received.
- Five good frames with `read_ready_i`=0 (FIFO_DEPTH=4) → count=4, `overflow_o`=1 and sticky, FIFO holds the first four. Repeat with a pop on the fifth stop edge → no overflow.
- Assert `rx_srst_i` at data bit 4 of frame 8'd197 → all outputs return to reset values; a fresh frame 8'd12 then decodes correctly.
